// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter needs at least one bit even when there is a single digit.
    function automatic int calc_cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// Combinational DIGIT-bit borrow-ripple subtract slice: {bo, d} = a_dig - b_dig - bi.
module sub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    assign {bo, d} = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, bi};

endmodule

// File: rtl/serial_sub.sv
// Digit-serial subtractor, LSB digit first, one reused DIGIT-wide slice.
// Define SERIAL_SUB_SAT_EN to clamp diff to 0 when the result borrows.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(NDIG);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_sub: DIGIT must be >= 1 and divide WIDTH");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             borrow_reg;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [DIGIT-1:0] d;
    logic             bo;
    logic [WIDTH-1:0] diff_shift;
    logic             last;

    sub_digit #(.DIGIT(DIGIT)) u_slice (
        .a_dig (a_sh[DIGIT-1:0]),
        .b_dig (b_sh[DIGIT-1:0]),
        .bi    (borrow_reg),
        .d     (d),
        .bo    (bo)
    );

    // New digit enters from the MSB side; after NDIG shifts the word is in place.
    assign diff_shift = WIDTH'({d, diff} >> DIGIT);
    assign last       = (cnt == CNT_W'(NDIG - 1));
    assign in_ready   = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            borrow_reg <= 1'b0;
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        cnt        <= '0;
                        borrow_reg <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    diff       <= diff_shift;
                    borrow_reg <= bo;
                    cnt        <= cnt + CNT_W'(1);
                    if (last) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        borrow    <= bo;
`ifdef SERIAL_SUB_SAT_EN
                        if (bo) diff <= '0;
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand shift registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_valid) begin
            a_sh <= a;
            b_sh <= b;
        end else if (state == S_RUN) begin
            a_sh <= a_sh >> DIGIT;
            b_sh <= b_sh >> DIGIT;
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: 8/2 main instance plus 8/8 and 7/1 sweep instances.
module tb_serial_sub;

    typedef struct {
        logic [7:0] d;
        logic       b;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, borrow;
    logic [7:0] diff;

    logic       s8_iv = 1'b0, s8_or = 1'b0;
    logic [7:0] s8_a = '0, s8_b = '0;
    logic       s8_ir, s8_ov, s8_bo;
    logic [7:0] s8_d;

    logic       s7_iv = 1'b0, s7_or = 1'b0;
    logic [6:0] s7_a = '0, s7_b = '0;
    logic       s7_ir, s7_ov, s7_bo;
    logic [6:0] s7_d;

    serial_sub #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow)
    );

    serial_sub #(.WIDTH(8), .DIGIT(8)) dut_w8d8 (
        .clk(clk), .rst(rst), .in_valid(s8_iv), .in_ready(s8_ir),
        .a(s8_a), .b(s8_b), .out_valid(s8_ov), .out_ready(s8_or),
        .diff(s8_d), .borrow(s8_bo)
    );

    serial_sub #(.WIDTH(7), .DIGIT(1)) dut_w7d1 (
        .clk(clk), .rst(rst), .in_valid(s7_iv), .in_ready(s7_ir),
        .a(s7_a), .b(s7_b), .out_valid(s7_ov), .out_ready(s7_or),
        .diff(s7_d), .borrow(s7_bo)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t sq[$];

    function automatic logic [7:0] model_diff(input logic [7:0] x, input logic [7:0] y, input int w);
        logic [7:0] m;
        logic [7:0] r;
        m = 8'hFF >> (8 - w);
        r = ((x & m) - (y & m)) & m;
`ifdef SERIAL_SUB_SAT_EN
        if ((x & m) < (y & m)) r = '0;
`endif
        return r;
    endfunction

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input int hold, input string name);
        exp_t e;
        int   lat;
        e.d = model_diff(ta, tbv, 8);
        e.b = (ta < tbv);
        q.push_back(e);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s in_ready_before_accept got=%b want=1", name, in_ready);
        end
        in_valid = 1'b1; a = ta; b = tbv;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        e = q.pop_front();
        n_vec++;
        if (lat != 4) begin
            n_bad++; $display("FAIL %s latency got=%0d want=4", name, lat);
        end
        n_vec++;
        if (diff !== e.d) begin
            n_bad++; $display("FAIL %s diff got=%h want=%h", name, diff, e.d);
        end
        n_vec++;
        if (borrow !== e.b) begin
            n_bad++; $display("FAIL %s borrow got=%b want=%b", name, borrow, e.b);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            n_vec++;
            if (diff !== e.d || borrow !== e.b || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s hold%0d got d=%h b=%b ov=%b ir=%b want d=%h b=%b ov=1 ir=0",
                         name, h, diff, borrow, out_valid, in_ready, e.d, e.b);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s handshake got ir=%b ov=%b want ir=1 ov=0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset got ov=%b d=%h b=%b ir=%b want ov=0 d=00 b=0 ir=1",
                     out_valid, diff, borrow, in_ready);
        end
    endtask

    task automatic test_no_borrow();
        run_op(8'h35, 8'h12, 0, "no_borrow");
    endtask

    task automatic test_borrow();
        run_op(8'h12, 8'h35, 0, "borrow");
    endtask

    task automatic test_full_chain();
        run_op(8'h00, 8'h01, 0, "chain_00_01");
        run_op(8'hA5, 8'hA5, 0, "equal_a5");
        run_op(8'hFF, 8'h00, 0, "ff_minus_0");
    endtask

    task automatic test_back_pressure();
        run_op(8'h5A, 8'h3C, 5, "back_pressure");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) run_op(8'($urandom), 8'($urandom), i % 2, "back_to_back");
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; a = 8'h9C; b = 8'h21;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid got ov=%b d=%h b=%b ir=%b want ov=0 d=00 b=0 ir=1",
                     out_valid, diff, borrow, in_ready);
        end
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_discard out_valid got=%b want=0", out_valid);
        end
        run_op(8'h80, 8'h01, 0, "after_reset");
    endtask

    function automatic logic sw_ov(input int idx);
        return (idx == 0) ? s8_ov : s7_ov;
    endfunction

    task automatic sweep_op(input int idx, input logic [7:0] ta, input logic [7:0] tbv);
        exp_t       e;
        int         w, nd, lat;
        logic [7:0] m, gd;
        logic       gb;
        w  = (idx == 0) ? 8 : 7;
        nd = (idx == 0) ? 1 : 7;
        m  = 8'hFF >> (8 - w);
        e.d = model_diff(ta, tbv, w);
        e.b = ((ta & m) < (tbv & m));
        sq.push_back(e);
        if (idx == 0) begin
            s8_iv = 1'b1; s8_a = ta; s8_b = tbv;
        end else begin
            s7_iv = 1'b1; s7_a = ta[6:0]; s7_b = tbv[6:0];
        end
        @(posedge clk); #1;
        s8_iv = 1'b0; s7_iv = 1'b0;
        lat = 0;
        while (sw_ov(idx) !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        gd = (idx == 0) ? s8_d : {1'b0, s7_d};
        gb = (idx == 0) ? s8_bo : s7_bo;
        e = sq.pop_front();
        n_vec++;
        if (lat != nd || gd !== e.d || gb !== e.b) begin
            n_bad++;
            $display("FAIL sweep_w%0d a=%h b=%h got lat=%0d d=%h bo=%b want lat=%0d d=%h bo=%b",
                     w, ta & m, tbv & m, lat, gd, gb, nd, e.d, e.b);
        end
        s8_or = (idx == 0); s7_or = (idx == 1);
        @(posedge clk); #1;
        s8_or = 1'b0; s7_or = 1'b0;
    endtask

    task automatic test_param_sweep();
        for (int idx = 0; idx < 2; idx++) begin
            sweep_op(idx, 8'h00, 8'hFF);
            sweep_op(idx, 8'hFF, 8'h00);
            sweep_op(idx, 8'h00, 8'h01);
            for (int i = 0; i < 20; i++) sweep_op(idx, 8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_no_borrow();
        test_borrow();
        test_full_chain();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
